// File: rtl/register_file_32x32.sv
// 32x32 register file: two registered read ports, one write port, r0 hardwired to zero.
// Optional same-edge write-to-read forwarding when REGFILE_WRITE_BYPASS_EN is defined.
module register_file_32x32 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned REG_COUNT  = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2
);

  logic [DATA_WIDTH-1:0] regQ [REG_COUNT];
  logic [DATA_WIDTH-1:0] dataR1Q, dataR2Q;
  logic [DATA_WIDTH-1:0] readR1, readR2;
  logic                  writeEn;

  // Writes to index 0 are dropped so r0 can never leave zero.
  assign writeEn = WRITE && (ADDR_W != '0);

  always_comb begin
    readR1 = '0;
    readR2 = '0;
    if (ADDR_R1 != '0) readR1 = regQ[ADDR_R1];
    if (ADDR_R2 != '0) readR2 = regQ[ADDR_R2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (writeEn && (ADDR_R1 == ADDR_W)) readR1 = DATA_W;
    if (writeEn && (ADDR_R2 == ADDR_W)) readR2 = DATA_W;
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(REG_COUNT); i++) regQ[i] <= '0;
    end else if (writeEn) begin
      regQ[ADDR_W] <= DATA_W;
    end
  end

  // Outputs hold while READ is low so ALU operands stay stable across a multi-cycle op.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dataR1Q <= '0;
      dataR2Q <= '0;
    end else if (READ) begin
      dataR1Q <= readR1;
      dataR2Q <= readR2;
    end
  end

  assign DATA_R1 = dataR1Q;
  assign DATA_R2 = dataR2Q;

endmodule
